exe_mem_pipe_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 64 ++++++
 rtl/exe_mem_pipe_stage.sv | 83 ++++++++
 tb/tb_exe_mem_pipe_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EXE->MEM pipeline register: default widths, control
// bundle and the full payload layout carried from execute into memory.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } exe_mem_ctrl_t;

  localparam int CTRL_W = $bits(exe_mem_ctrl_t);

  // Payload at default widths; the stage packs the same field order at any width.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [REG_AW_DEF-1:0] dst_reg;
    logic [DATA_W_DEF-1:0] rt_data;
    exe_mem_ctrl_t         ctrl;
  } exe_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. Main entry drives the outputs,
// skid entry absorbs one overflow; bits in CLEAR_MASK are zeroed on bubbles.
module pipe_skid_buf #(
  parameter int             W          = 8,
  parameter logic [W-1:0]   CLEAR_MASK = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never depends on ready, and in_ready is purely registered.
  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         release_beat;

  assign in_ready     = ~skid_valid;
  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign accept       = in_valid & in_ready;
  assign release_beat = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= main_data & ~CLEAR_MASK;
      skid_data  <= skid_data & ~CLEAR_MASK;
    end else if (!main_valid || release_beat) begin
      if (skid_valid) begin
        // in_ready was low, so nothing can be accepted this cycle.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= skid_data & ~CLEAR_MASK;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= main_data & ~CLEAR_MASK;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage wrapping pipe_skid_buf with control-bit bubble
// clearing. Optional stall counter enabled by macro EXE_MEM_STALL_CNT_EN.
module exe_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [REG_AW-1:0] exe_dst_reg,
  input  logic [DATA_W-1:0] exe_rt_data,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_AW-1:0] mem_dst_reg,
  output logic [DATA_W-1:0] mem_rt_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write
`ifdef EXE_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PW = 2 * DATA_W + REG_AW + CTRL_W;
  // Control bits sit in the low end of the packed payload.
  localparam logic [PW-1:0] CTRL_MASK = {{(PW - CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

  exe_mem_ctrl_t   in_ctrl;
  exe_mem_ctrl_t   out_ctrl;
  logic [PW-1:0]   in_data;
  logic [PW-1:0]   out_data;

  assign in_ctrl = '{mem_read:   mem_read_in,
                     mem_write:  mem_write_in,
                     mem_to_reg: mem_to_reg_in,
                     reg_write:  reg_write_in};
  assign in_data = {exe_result, exe_dst_reg, exe_rt_data, in_ctrl};

  pipe_skid_buf #(
    .W          (PW),
    .CLEAR_MASK (CTRL_MASK)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {mem_result, mem_dst_reg, mem_rt_data, out_ctrl} = out_data;
  assign mem_read   = out_ctrl.mem_read;
  assign mem_write  = out_ctrl.mem_write;
  assign mem_to_reg = out_ctrl.mem_to_reg;
  assign reg_write  = out_ctrl.reg_write;

`ifdef EXE_MEM_STALL_CNT_EN
  // Saturating; survives flush so stall statistics span pipeline kills.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Directed self-checking bench for exe_mem_pipe_stage: reset, streaming,
// bubbles, stall/skid ordering, flush, mid-stall reset and optional counter.
module tb_exe_mem_pipe_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] exe_result;
  logic [AW-1:0] exe_dst_reg;
  logic [DW-1:0] exe_rt_data;
  logic          mem_read_in;
  logic          mem_write_in;
  logic          mem_to_reg_in;
  logic          reg_write_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] mem_result;
  logic [AW-1:0] mem_dst_reg;
  logic [DW-1:0] mem_rt_data;
  logic          mem_read;
  logic          mem_write;
  logic          mem_to_reg;
  logic          reg_write;
`ifdef EXE_MEM_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  exe_mem_pipe_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .exe_result    (exe_result),
    .exe_dst_reg   (exe_dst_reg),
    .exe_rt_data   (exe_rt_data),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .reg_write_in  (reg_write_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .mem_result    (mem_result),
    .mem_dst_reg   (mem_dst_reg),
    .mem_rt_data   (mem_rt_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write)
`ifdef EXE_MEM_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one beat; ctrl = {mem_read, mem_write, mem_to_reg, reg_write}
  task automatic drive(input logic v, input logic [DW-1:0] res, input logic [3:0] ctrl);
    in_valid      = v;
    exe_result    = res;
    exe_dst_reg   = res[AW-1:0];
    exe_rt_data   = res + 32'h100;
    mem_read_in   = ctrl[3];
    mem_write_in  = ctrl[2];
    mem_to_reg_in = ctrl[1];
    reg_write_in  = ctrl[0];
  endtask

  function automatic logic [3:0] ctrl_out();
    return {mem_read, mem_write, mem_to_reg, reg_write};
  endfunction

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 4'hF);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 4'h0);

    // reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", mem_result, 32'h0);
    chk("rst_rt", mem_rt_data, 32'h0);
    chk("rst_dst", mem_dst_reg, 5'h0);
    chk("rst_ctrl", ctrl_out(), 4'h0);
`ifdef EXE_MEM_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // streaming: 1-cycle latency, one beat per cycle, in_ready stays high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 4'b0001);
      exp_q.push_back(DW'(i));
      tick();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_reg_write", reg_write, 1'b1);
      if (exp_q.size() > 0) chk("stream_result", mem_result, exp_q.pop_front());
    end
    chk("stream_dst", mem_dst_reg, 5'd8);
    chk("stream_rt", mem_rt_data, 32'h108);

    // bubbles with control bits on the idle bus
    drive(1'b0, 32'h77, 4'b0100);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bubble_valid", out_valid, 1'b0);
      chk("bubble_mem_write", mem_write, 1'b0);
      chk("bubble_reg_write", reg_write, 1'b0);
    end

    // stall: A held in main, B in skid, C refused while full
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 4'b0100);
    tick();
    chk("stall_a_valid", out_valid, 1'b1);
    chk("stall_a_in_ready", in_ready, 1'b1);
    drive(1'b1, 32'h20, 4'b1010);
    tick();
    chk("stall_a_held", mem_result, 32'h10);
    chk("stall_a_ctrl", ctrl_out(), 4'b0100);
    chk("stall_in_ready_low", in_ready, 1'b0);
    drive(1'b1, 32'h30, 4'b0001);
    tick();
    chk("stall_a_still", mem_result, 32'h10);
    chk("stall_in_ready_still", in_ready, 1'b0);
    drive(1'b0, 32'h0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk("stall_b_valid", out_valid, 1'b1);
    chk("stall_b_result", mem_result, 32'h20);
    chk("stall_b_ctrl", ctrl_out(), 4'b1010);
    chk("stall_b_in_ready", in_ready, 1'b1);
    tick();
    chk("stall_drained", out_valid, 1'b0);
    chk("stall_no_c", ctrl_out(), 4'h0);

    // flush with both entries full and a live input on the bus
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 4'b0001);
    tick();
    drive(1'b1, 32'h50, 4'b0010);
    tick();
    chk("flush_pre_in_ready", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h60, 4'b1111);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", ctrl_out(), 4'h0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_skid_leak", out_valid, 1'b0);
    drive(1'b1, 32'h70, 4'b0001);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_result", mem_result, 32'h70);
    tick();

    // reset mid-stall beats a simultaneous flush and clears everything
    out_ready = 1'b0;
    drive(1'b1, 32'h80, 4'b1111);
    tick();
    drive(1'b1, 32'h90, 4'b1111);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_result", mem_result, 32'h0);
    chk("mrst_rt", mem_rt_data, 32'h0);
    chk("mrst_dst", mem_dst_reg, 5'h0);
    chk("mrst_ctrl", ctrl_out(), 4'h0);
`ifdef EXE_MEM_STALL_CNT_EN
    chk("mrst_stall_cnt", stall_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("mrst_no_skid", out_valid, 1'b0);

`ifdef EXE_MEM_STALL_CNT_EN
    // counter: five stalled cycles, then flush while MEM is ready
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 4'b0001);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    chk("cnt_start", stall_cnt, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("cnt_five", stall_cnt, 32'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_after_flush", stall_cnt, 32'd5);
    tick();
    chk("cnt_hold", stall_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
